uart_transmitter: RTL and testbench

UART_TRANSMITTER -- requirements
Module: uart_transmitter

---
 rtl/uart_transmitter.sv | 115 +++++++++++
 tb/tb_uart_transmitter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_transmitter.sv
// ============================================================================
//  Module   : uart_transmitter
//  Brief    : 8-bit UART transmitter, 1 start / 8 data (LSB first) / parity /
//             1 stop, with a four-phase send/sent handshake.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_transmitter #(
  parameter int CLK_FREQUENCY = 100_000_000,
  parameter int BAUD_RATE     = 19_200,
  parameter int PARITY        = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       send,
  input  logic [7:0] din,
  output logic       tx_out,
  output logic       busy,
  output logic       sent
);

  localparam int                 c_BIT_CYCLES = CLK_FREQUENCY / BAUD_RATE;
  localparam int                 c_CNT_W      = (c_BIT_CYCLES > 1) ? $clog2(c_BIT_CYCLES) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST   = c_CNT_W'(c_BIT_CYCLES - 1);
  localparam logic               c_ODD        = (PARITY != 0);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_PAR   = 3'd3,
    S_STOP  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t             r_state, w_state_next;
  logic [c_CNT_W-1:0] r_cnt, w_cnt_next;
  logic [2:0]         r_idx, w_idx_next;
  logic [7:0]         r_din, w_din_next;
  logic               r_tx, w_tx_next;
  logic               w_bit_done;

  assign w_bit_done = (r_cnt == c_CNT_LAST);

  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_din_next   = r_din;
    case (r_state)
      S_IDLE: begin
        if (send) begin
          w_state_next = S_START;
          w_din_next   = din;
          w_idx_next   = 3'd0;
        end
      end
      S_START: if (w_bit_done) w_state_next = S_DATA;
      S_DATA: begin
        if (w_bit_done) begin
          if (r_idx == 3'd7) w_state_next = S_PAR;
          else               w_idx_next   = r_idx + 3'd1;
        end
      end
      S_PAR:  if (w_bit_done) w_state_next = S_STOP;
      S_STOP: if (w_bit_done) w_state_next = S_DONE;
      S_DONE: if (!send)      w_state_next = S_IDLE;
      default:                w_state_next = S_IDLE;
    endcase
  end

  // Bit timer restarts at every bit boundary and is parked at zero outside a frame.
  always_comb begin
    w_cnt_next = r_cnt + c_CNT_W'(1);
    if ((w_state_next != r_state) || w_bit_done ||
        (r_state == S_IDLE) || (r_state == S_DONE)) begin
      w_cnt_next = '0;
    end
  end

  // Line level is computed from the next state so tx_out changes on the same edge.
  always_comb begin
    w_tx_next = 1'b1;
    case (w_state_next)
      S_START: w_tx_next = 1'b0;
      S_DATA:  w_tx_next = w_din_next[w_idx_next];
      S_PAR:   w_tx_next = (^w_din_next) ^ c_ODD;
      default: w_tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= 3'd0;
      r_din   <= 8'd0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_idx   <= w_idx_next;
      r_din   <= w_din_next;
      r_tx    <= w_tx_next;
    end
  end

  assign tx_out = r_tx;
  assign busy   = (r_state == S_START) || (r_state == S_DATA) ||
                  (r_state == S_PAR)   || (r_state == S_STOP);
  assign sent   = (r_state == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_uart_transmitter.sv
// ============================================================================
//  Module   : tb_uart_transmitter
//  Brief    : Directed self-checking bench for uart_transmitter (BIT_CYCLES=10).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_transmitter;

  localparam int c_CLK_FREQ = 1000;
  localparam int c_BAUD     = 100;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       send = 1'b0;
  logic       send_b = 1'b0;
  logic [7:0] din = 8'h00;
  logic [7:0] din_b = 8'h00;
  logic       tx_out, busy, sent;
  logic       tx_b, busy_b, sent_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_transmitter #(
    .CLK_FREQUENCY(c_CLK_FREQ),
    .BAUD_RATE    (c_BAUD),
    .PARITY       (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .send  (send),
    .din   (din),
    .tx_out(tx_out),
    .busy  (busy),
    .sent  (sent)
  );

  uart_transmitter #(
    .CLK_FREQUENCY(c_CLK_FREQ),
    .BAUD_RATE    (c_BAUD),
    .PARITY       (0)
  ) dut_even (
    .clk   (clk),
    .reset (reset),
    .send  (send_b),
    .din   (din_b),
    .tx_out(tx_b),
    .busy  (busy_b),
    .sent  (sent_b)
  );

  // Frame on the odd-parity DUT; par is the hand-computed parity bit.
  // Starts and ends on a falling edge, ends one cycle after DONE with line idle.
  task automatic run_frame(input logic [7:0] d, input logic par, input int toggle,
                           input int din_change_at, input int hold);
    logic [10:0] fb;
    fb   = {1'b1, par, d, 1'b0};
    din  = d;
    send = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 110; i++) begin
      checks++;
      if (tx_out !== fb[i/10] || busy !== 1'b1 || sent !== 1'b0) begin
        failures++;
        $display("FAIL frame_%h cycle %0d: tx=%b busy=%b sent=%b, required tx=%b busy=1 sent=0",
                 d, i, tx_out, busy, sent, fb[i/10]);
      end
      if (din_change_at == i) din = ~d;
      if (toggle != 0) send = ((i % 3) == 1);
      @(negedge clk);
    end
    checks++;
    if (sent !== 1'b1 || busy !== 1'b0 || tx_out !== 1'b1) begin
      failures++;
      $display("FAIL done_%h: sent=%b busy=%b tx=%b, required sent=1 busy=0 tx=1",
               d, sent, busy, tx_out);
    end
    for (int i = 0; i < hold; i++) begin
      send = 1'b1;
      @(negedge clk);
      checks++;
      if (sent !== 1'b1 || busy !== 1'b0 || tx_out !== 1'b1) begin
        failures++;
        $display("FAIL hold_%0d: sent=%b busy=%b tx=%b, required sent=1 busy=0 tx=1",
                 i, sent, busy, tx_out);
      end
    end
    send = 1'b0;
    @(negedge clk);
    checks++;
    if (sent !== 1'b0 || busy !== 1'b0 || tx_out !== 1'b1) begin
      failures++;
      $display("FAIL idle_after_%h: sent=%b busy=%b tx=%b, required sent=0 busy=0 tx=1",
               d, sent, busy, tx_out);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    send  = 1'b1;
    #12;
    checks++;
    if (tx_out !== 1'b1 || busy !== 1'b0 || sent !== 1'b0 ||
        tx_b !== 1'b1 || busy_b !== 1'b0 || sent_b !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: tx=%b busy=%b sent=%b tx_b=%b busy_b=%b sent_b=%b, required 1 0 0 1 0 0",
               tx_out, busy, sent, tx_b, busy_b, sent_b);
    end
    @(negedge clk);
    send  = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (tx_out !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_idle: tx=%b busy=%b, required tx=1 busy=0", tx_out, busy);
    end
  endtask

  task automatic test_basic();
    run_frame(8'h41, 1'b1, 0, -1, 0);
  endtask

  task automatic test_parity();
    run_frame(8'h07, 1'b0, 0, -1, 0);
    run_frame(8'h00, 1'b1, 0, -1, 0);
  endtask

  task automatic test_even_parity();
    logic [10:0] fb;
    fb     = {1'b1, 1'b0, 8'hFF, 1'b0};
    din_b  = 8'hFF;
    send_b = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 110; i++) begin
      checks++;
      if (tx_b !== fb[i/10] || busy_b !== 1'b1) begin
        failures++;
        $display("FAIL even_frame cycle %0d: tx=%b busy=%b, required tx=%b busy=1",
                 i, tx_b, busy_b, fb[i/10]);
      end
      @(negedge clk);
    end
    checks++;
    if (sent_b !== 1'b1 || tx_b !== 1'b1) begin
      failures++;
      $display("FAIL even_done: sent=%b tx=%b, required sent=1 tx=1", sent_b, tx_b);
    end
    send_b = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_din_change();
    run_frame(8'h41, 1'b1, 0, 25, 0);
  endtask

  task automatic test_send_toggle();
    run_frame(8'h5A, 1'b1, 1, -1, 0);
  endtask

  task automatic test_hold();
    run_frame(8'h41, 1'b1, 0, -1, 189);
    repeat (15) @(negedge clk);
    checks++;
    if (tx_out !== 1'b1 || busy !== 1'b0 || sent !== 1'b0) begin
      failures++;
      $display("FAIL no_second_frame: tx=%b busy=%b sent=%b, required tx=1 busy=0 sent=0",
               tx_out, busy, sent);
    end
  endtask

  task automatic test_back_to_back();
    run_frame(8'hA5, 1'b1, 0, -1, 0);
    run_frame(8'h80, 1'b0, 0, -1, 0);
  endtask

  task automatic test_reset_midframe();
    din  = 8'h41;
    send = 1'b1;
    @(negedge clk);
    repeat (47) @(negedge clk);
    checks++;
    if (tx_out !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL pre_abort cycle 47: tx=%b busy=%b, required tx=0 busy=1", tx_out, busy);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (tx_out !== 1'b1 || busy !== 1'b0 || sent !== 1'b0) begin
      failures++;
      $display("FAIL async_abort: tx=%b busy=%b sent=%b, required tx=1 busy=0 sent=0",
               tx_out, busy, sent);
    end
    @(negedge clk);
    reset = 1'b1;
    run_frame(8'h41, 1'b1, 0, -1, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_even_parity();
    test_din_change();
    test_send_toggle();
    test_hold();
    test_back_to_back();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
